// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, GF(2^8) helper and cipher FSM encodings.
// No timing of its own; pure declarations.
// No flow control; consumed by the cipher and key-expansion blocks.
package aes_pkg;

    localparam int NB      = 4;        // columns in the state
    localparam int BLOCK_W = 32 * NB;  // 128-bit block

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_e;

    // Multiply by x in GF(2^8) mod 0x11b; bit 0 is the byte MSB.
    function automatic logic [0:7] xtime(input logic [0:7] b);
        return {b[1:7], 1'b0} ^ (b[0] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, 8-bit combinational lookup.
// Zero latency.
// No flow control.
module aes_sbox (
    input  logic [0:7] din,
    output logic [0:7] dout
);

    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX_TBL[{din, 3'b000} +: 8];

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption, one round per clock on a single state register.
// Latency: out_valid rises Nr cycles after the accept edge; one block per Nr+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready is low whenever not IDLE.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [0:BLOCK_W-1]         in_data,
    input  logic [0:BLOCK_W*(Nr+1)-1]  key_sched,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [0:BLOCK_W-1]         out_data,
    output logic                       busy
);

    localparam int RW = $clog2(Nr + 1);
    localparam logic [RW-1:0] RND_LAST = RW'(Nr);

    // A mismatched key length / round count pair cannot produce valid ciphertext.
    if (Nr != Nk + 6) begin : g_param_err
        $error("aes_cipher_iter: Nr (%0d) must equal Nk+6 (Nk=%0d)", Nr, Nk);
    end

    aes_state_e          fsm_cur;
    aes_state_e          fsm_nxt;
    logic [0:BLOCK_W-1]  blk;
    logic [RW-1:0]       rnd;
    logic                load_init;
    logic                load_round;
    logic                last_rnd;

    logic [0:BLOCK_W-1]  rk [0:Nr];
    logic [0:BLOCK_W-1]  sb_out;
    logic [0:BLOCK_W-1]  sr_out;
    logic [0:BLOCK_W-1]  mc_out;
    logic [0:BLOCK_W-1]  round_out;

    // Round keys sliced straight from the unregistered schedule.
    for (genvar r = 0; r <= Nr; r++) begin : g_rk
        assign rk[r] = key_sched[BLOCK_W*r +: BLOCK_W];
    end

    // SubBytes: one S-box per state byte.
    for (genvar i = 0; i < 4*NB; i++) begin : g_sub
        aes_sbox u_sbox (
            .din  (blk[8*i +: 8]),
            .dout (sb_out[8*i +: 8])
        );
    end

    // ShiftRows: row r of column c comes from column (c+r) mod 4.
    for (genvar c = 0; c < NB; c++) begin : g_shift_c
        for (genvar r = 0; r < 4; r++) begin : g_shift_r
            assign sr_out[8*(4*c+r) +: 8] = sb_out[8*(4*((c+r)%NB)+r) +: 8];
        end
    end

    // MixColumns: fixed {02,03,01,01} circulant per column.
    for (genvar c = 0; c < NB; c++) begin : g_mix
        logic [0:7] a0, a1, a2, a3;
        assign a0 = sr_out[32*c      +: 8];
        assign a1 = sr_out[32*c + 8  +: 8];
        assign a2 = sr_out[32*c + 16 +: 8];
        assign a3 = sr_out[32*c + 24 +: 8];
        assign mc_out[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mc_out[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mc_out[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mc_out[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    assign last_rnd  = (rnd == RND_LAST);
    // The final round skips MixColumns.
    assign round_out = (last_rnd ? sr_out : mc_out) ^ rk[rnd];
    assign out_data  = blk;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_cur <= ST_IDLE;
        end else begin
            fsm_cur <= fsm_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        fsm_nxt    = fsm_cur;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        load_init  = 1'b0;
        load_round = 1'b0;
        case (fsm_cur)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_init = 1'b1;
                    fsm_nxt   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                busy       = 1'b1;
                load_round = 1'b1;
                if (last_rnd) begin
                    fsm_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_nxt = ST_IDLE;
                end
            end
            default: begin
                fsm_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and round counter; counter saturates at Nr until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk <= '0;
            rnd <= '0;
        end else if (load_init) begin
            blk <= in_data ^ rk[0];
            rnd <= RW'(1);
        end else if (load_round) begin
            blk <= round_out;
            if (!last_rnd) begin
                rnd <= rnd + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench: AES-128/192/256 cores fed from a behavioural key expansion.
// Expected ciphertexts enter a per-core scoreboard on accept and are compared on output.
// Exercises latency, backpressure, async reset mid-block and back-to-back throughput.
module tb_aes_cipher_iter;

    localparam logic [255:0] K_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K_C2  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid  [3];
    logic          in_ready  [3];
    logic [0:127]  in_data   [3];
    logic          out_valid [3];
    logic          out_ready [3];
    logic [0:127]  out_data  [3];
    logic          busy      [3];
    logic [127:0]  in_exp    [3];
    logic [0:1919] ks_full   [3];

    logic [7:0]    sbt [256];
    logic [127:0]  exp_q [3][$];
    int            acc_q [3][$];
    logic          prev_ov [3];
    int            n_rcv [3];
    int            exp_n [3];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int NK = 4 + 2*g;
        localparam int NR = NK + 6;
        logic [0:128*(NR+1)-1] key_sched;
        assign key_sched = ks_full[g][0 +: 128*(NR+1)];
        aes_cipher_iter #(.Nk(NK), .Nr(NR)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .key_sched (key_sched),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
    endfunction

    function automatic logic [0:1919] kexp(input logic [0:255] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1919] r;
        int            nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        r  = '0;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    // Scoreboard: push on accept, check latency on out_valid rise, pop on transfer.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                exp_q[k].delete();
                acc_q[k].delete();
                prev_ov[k] <= 1'b0;
            end else begin
                if (in_valid[k] && in_ready[k]) begin
                    exp_q[k].push_back(in_exp[k]);
                    acc_q[k].push_back(cyc + 1);
                end
                if (out_valid[k] && !prev_ov[k] && acc_q[k].size() > 0)
                    check($sformatf("latency%0d", k), cyc - acc_q[k].pop_front(), 10 + 2*k);
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0)
                        check($sformatf("spurious_out%0d", k), out_valid[k], 0);
                    else
                        check($sformatf("ct%0d", k), out_data[k], exp_q[k].pop_front());
                    n_rcv[k] <= n_rcv[k] + 1;
                end
                prev_ov[k] <= out_valid[k];
            end
        end
    end

    task automatic send(input int k, input logic [127:0] pt, input logic [127:0] ct);
        logic ok = 1'b0;
        @(posedge clk); #1;
        in_valid[k] = 1'b1;
        in_data[k]  = pt;
        in_exp[k]   = ct;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready[k];
        end
        check($sformatf("accept%0d", k), ok, 1);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_rcv(input int k, input int n);
        for (int t = 0; t < 200 && n_rcv[k] < n; t++) @(posedge clk);
        #1;
        check($sformatf("rcv_count%0d", k), n_rcv[k], n);
    endtask

    initial begin
        int nacc;
        int ot[$];
        logic seen;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; in_data[k] = '0; in_exp[k] = '0;
            out_ready[k] = 1'b1; exp_n[k] = 0;
        end
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbt[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        ks_full[0] = kexp(K_B, 4);
        ks_full[1] = kexp(K_C2, 6);
        ks_full[2] = kexp(K_C3, 8);

        // Reset values
        repeat (3) @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_in_ready%0d", k), in_ready[k], 1);
            check($sformatf("rst_out_valid%0d", k), out_valid[k], 0);
            check($sformatf("rst_busy%0d", k), busy[k], 0);
            check($sformatf("rst_out_data%0d", k), out_data[k], 0);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;

        // FIPS-197 vectors, one per key size
        send(0, PT_B, CT_B);  exp_n[0]++;
        send(1, PT_C, CT_C2); exp_n[1]++;
        send(2, PT_C, CT_C3); exp_n[2]++;
        for (int k = 0; k < 3; k++) wait_rcv(k, exp_n[k]);

        // Backpressure: hold DONE for several cycles with a competing in_valid
        out_ready[0] = 1'b0;
        send(0, PT_B, CT_B); exp_n[0]++;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid[0];
        end
        check("bp_out_valid_rise", seen, 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b1; in_data[0] = PT_C; in_exp[0] = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid[0], 1);
            check("bp_out_data", out_data[0], CT_B);
            check("bp_in_ready", in_ready[0], 0);
            check("bp_busy", busy[0], 1);
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", in_ready[0], 1);
        check("bp_release_out_valid", out_valid[0], 0);
        send(0, PT_B, CT_B); exp_n[0]++;
        wait_rcv(0, exp_n[0]);

        // Asynchronous reset at round 5; the in-flight block must vanish
        send(0, PT_B, CT_B);
        repeat (4) @(posedge clk); #2;
        check("mid_busy_before_rst", busy[0], 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid[0], 0);
        check("mid_rst_in_ready", in_ready[0], 1);
        check("mid_rst_busy", busy[0], 0);
        check("mid_rst_out_data", out_data[0], 0);
        repeat (2) @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (15) @(posedge clk); #1;
        check("mid_rst_no_stale", n_rcv[0], exp_n[0]);
        send(0, PT_B, CT_B); exp_n[0]++;
        wait_rcv(0, exp_n[0]);

        // Back-to-back with in_valid held high and a new key
        ks_full[0] = kexp(K_C1, 4);
        @(posedge clk); #1;
        in_valid[0] = 1'b1; in_data[0] = PT_C; in_exp[0] = CT_C1;
        nacc = 0;
        for (int t = 0; t < 300 && (nacc < 4 || ot.size() < 4); t++) begin
            @(negedge clk);
            if (out_valid[0]) ot.push_back(cyc);
            if (in_valid[0] && in_ready[0]) begin
                nacc++;
                if (nacc == 4) begin
                    @(posedge clk); #1;
                    in_valid[0] = 1'b0;
                end
            end
        end
        exp_n[0] += 4;
        check("b2b_outputs", ot.size(), 4);
        for (int i = 1; i < ot.size(); i++)
            check($sformatf("b2b_spacing%0d", i), ot[i] - ot[i-1], 12);
        wait_rcv(0, exp_n[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
